i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Serializes the 24-bit mono equalizer output into a standard I2S stream for the audio codec DAC.
- Generates bclk, lrclk and sdata from the system clock.
- Sits at the output of the DSP chain, after the band-summing stage.
- Accepts one sample per frame through a valid/ready handshake and duplicates it onto the left and right slots.

Parameters:
- DATA_W, 24, sample width. Must be ≤ SLOT_W-1.
- SLOT_W, 32, bclk periods per channel slot. Frame length is 2*SLOT_W.
- BCLK_DIV, 4, clk cycles per bclk half-period. Must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- rst  in  1  synchronous, active-low reset
- sam_in  in  DATA_W  two's-complement audio sample from the equalizer
- sam_valid  in  1  sam_in is valid
- sam_ready  out  1  the holding register is empty and can accept a sample
- bclk  out  1  I2S bit clock
- lrclk  out  1  word select: 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- frame_start  out  1  one-clk pulse when a new frame word is loaded
- underrun  out  1  one-clk pulse when a frame is loaded while the holding register is empty

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: bclk=0, lrclk=0, sdata=0, sam_ready=1, frame_start=0, underrun=0.
  - Internal state: div_cnt=0, bit_cnt=2*SLOT_W-1, holding register empty, hold_reg=0, frame_word=0.
  - Reset mid-frame aborts the frame immediately; no partial slot completes.
- Handshake:
  - Accept when sam_valid && sam_ready: hold_reg <= sam_in, full <= 1.
  - sam_ready = !full, registered.
  - sam_in is ignored when sam_ready=0.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1. At terminal count it wraps and bclk toggles.
  - bclk period is therefore 2*BCLK_DIV clk cycles.
- Falling-edge events (the clk cycle in which bclk toggles 1->0):
  - bit_cnt increments modulo 2*SLOT_W. Call the new value n, and p = n mod SLOT_W.
  - lrclk <= (n >= SLOT_W).
  - sdata <= frame_word[DATA_W-p] when 1 ≤ p ≤ DATA_W, otherwise 0. This gives the I2S one-bit delay after the lrclk transition and zero padding in the LSB slot positions.
  - When n == 0 (frame boundary):
    - frame_start pulses for one clk.
    - If full: frame_word <= hold_reg and full <= 0.
    - If empty: frame_word keeps its previous value and underrun pulses for one clk.
    - The frame_word update takes effect before p=1 is driven.
- Outputs change only on falling-edge events, so the codec samples on rising bclk.
- The same frame_word is sent in the left and right slots.
- First falling edge after reset occurs 2*BCLK_DIV clks after reset release; it is a frame boundary (n=0).
- Simultaneous events:
  - Accept and frame load in the same clk with the holding register empty: the load uses the pre-edge (empty) state, so underrun pulses and the accepted sample is held for the next frame.
  - With the holding register full, sam_ready=0, so accept and load cannot collide.
- Throughput: at most one sample per 2*SLOT_W*2*BCLK_DIV clks. The upstream stage must tolerate back-pressure.

Test Plan:
- Reset, BCLK_DIV=2, no valid -> bclk period 4 clk; lrclk low for 32 bclk then high for 32; sdata stays 0; underrun pulses once every 256 clk; sam_ready=1.
- Single sample 0xABCDEF before the first frame -> in the left slot, p=0 is 0, p=1..24 carry 1010_1011_1100_1101_1110_1111, p=25..31 are 0; the right slot is identical; frame_start pulses once; no underrun.
- Back-pressure: 0x000001, then 0x800000 presented continuously -> sam_ready=0 from acceptance of the first sample until its frame load; second sample accepted the clk after; next frame MSB=1 followed by zeros.
- Underrun: one sample 0x7FFFFF, then nothing -> the second frame repeats 0x7FFFFF with an underrun pulse at its n=0.
- Reset asserted mid-left-slot (p=10) for 1 clk -> all outputs and counters return to reset values the next clk; next falling edge is 2*BCLK_DIV clks after release with lrclk=0.
- Same-cycle accept and empty frame load -> underrun=1 in that clk; the sample appears in the following frame.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: takes one mono sample per frame over valid/ready and sends it
// MSB first in both the left and right slots, with bclk/lrclk derived from clk.
module i2s_tx #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sam_in,
    input  logic              sam_valid,
    output logic              sam_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun
);

    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int DIV_W = $clog2(BCLK_DIV);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0]  SLOT_N   = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0]  DATA_N   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] LSB_ONE  = DATA_W'(1);

    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_next;
    logic [CNT_W-1:0]  slot_pos;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] frame_word;
    logic [DATA_W-1:0] bit_mask;
    logic              full;
    logic              full_next;
    logic              accept;
    logic              fall_evt;
    logic              frame_evt;
    logic              load;
    logic              sdata_next;

    // Handshake: a sample transfers on any clk edge where sam_valid && sam_ready;
    // sam_ready is a registered !full, and sam_in is ignored while it is low.
    assign accept = sam_valid && sam_ready;

    // The falling bclk edge is the terminal divider count while bclk is high.
    assign fall_evt  = bclk && (div_cnt == DIV_LAST);
    assign bit_next  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + CNT_ONE;
    assign frame_evt = fall_evt && (bit_next == '0);
    assign load      = frame_evt && full;

    assign slot_pos  = (bit_next >= SLOT_N) ? bit_next - SLOT_N : bit_next;
    assign bit_mask  = LSB_ONE << (DATA_N - slot_pos);

    always_comb begin
        sdata_next = 1'b0;
        // Position 0 carries the one-bit I2S delay; positions past DATA_W are padding.
        if ((slot_pos >= CNT_ONE) && (slot_pos <= DATA_N)) begin
            sdata_next = |(frame_word & bit_mask);
        end
    end

    always_comb begin
        full_next = full;
        // A load decides on the pre-edge state, so an accept racing an empty load
        // still reports underrun and the new sample waits for the next frame.
        if (load) begin
            full_next = 1'b0;
        end else if (accept) begin
            full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_LAST;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            full        <= 1'b0;
            sam_ready   <= 1'b1;
            hold_reg    <= '0;
            frame_word  <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            full        <= full_next;
            sam_ready   <= !full_next;
            frame_start <= frame_evt;
            underrun    <= frame_evt && !full;

            if (accept) begin
                hold_reg <= sam_in;
            end
            if (load) begin
                frame_word <= hold_reg;
            end

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= !bclk;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end

            // Serial outputs move only on falling bclk so the codec samples on rising.
            if (fall_evt) begin
                bit_cnt <= bit_next;
                lrclk   <= (bit_next >= SLOT_N);
                sdata   <= sdata_next;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle-level reference model on every clk plus codec-view
// slot captures for a table of samples and the multi-frame corner cases.
module tb_i2s_tx;

    localparam int DW         = 24;
    localparam int SW         = 32;
    localparam int D          = 2;
    localparam int FRAME_CLKS = 2 * SW * 2 * D;
    localparam logic [2*SW-1:0] LR_PATTERN = {{SW{1'b0}}, {SW{1'b1}}};

    logic          clk;
    logic          rst;
    logic [DW-1:0] sam_in;
    logic          sam_valid;
    logic          sam_ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          frame_start;
    logic          underrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [SW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] sample;
        logic [SW-1:0] slot;
    } vec_t;

    typedef struct {
        int            k;
        logic          full;
        logic [DW-1:0] hold;
        logic [DW-1:0] word;
        logic          bclk;
        logic          lr;
        logic          sd;
        logic          ready;
        logic          fs;
        logic          ur;
    } mstate_t;

    mstate_t ms;
    bit      model_live = 1'b0;

    i2s_tx #(
        .DATA_W  (DW),
        .SLOT_W  (SW),
        .BCLK_DIV(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sam_in     (sam_in),
        .sam_valid  (sam_valid),
        .sam_ready  (sam_ready),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] slot_of(input logic [DW-1:0] s);
        logic [SW-1:0] r;
        r = '0;
        r[SW-2 -: DW] = s;
        return r;
    endfunction

    // Reference model: frame timing is derived from elapsed clks since reset release.
    function automatic mstate_t model_reset();
        mstate_t r;
        r.k = 0; r.full = 1'b0; r.hold = '0; r.word = '0;
        r.bclk = 1'b0; r.lr = 1'b0; r.sd = 1'b0; r.ready = 1'b1;
        r.fs = 1'b0; r.ur = 1'b0;
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic valid,
                                           input logic [DW-1:0] din);
        mstate_t       r;
        logic          bnd;
        int            n;
        int            p;
        logic [DW-1:0] sh;
        r   = s;
        r.k = s.k + 1;
        bnd = (r.k >= 2 * D) && (((r.k - 2 * D) % FRAME_CLKS) == 0);
        r.fs = bnd;
        r.ur = bnd && !s.full;
        if (bnd && s.full) begin
            r.word = s.hold;
            r.full = 1'b0;
        end
        if (valid && s.ready) begin
            r.hold = din;
            r.full = 1'b1;
        end
        r.ready = !r.full;
        r.bclk  = ((r.k / D) % 2) == 1;
        if ((r.k % (2 * D)) == 0) begin
            n    = (r.k / (2 * D) - 1) % (2 * SW);
            p    = n % SW;
            r.lr = (n >= SW);
            sh   = r.word >> (DW - p);
            r.sd = (p >= 1 && p <= DW) ? sh[0] : 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            ms         <= model_reset();
            model_live <= 1'b1;
        end else if (model_live) begin
            ms <= model_step(ms, sam_valid, sam_in);
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check($sformatf("cycle@%0t", $time),
                  64'({bclk, lrclk, sdata, sam_ready, frame_start, underrun}),
                  64'({ms.bclk, ms.lr, ms.sd, ms.ready, ms.fs, ms.ur}));
        end
    end

    // driver tasks
    task automatic wait_fs(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && i < FRAME_CLKS + 16) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_frame_start_seen"}, 64'(frame_start), 64'(1));
    endtask

    task automatic send_sample(input string tag, input logic [DW-1:0] s);
        int i;
        i = 0;
        while (sam_ready !== 1'b1 && i < FRAME_CLKS + 16) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_ready_seen"}, 64'(sam_ready), 64'(1));
        sam_valid = 1'b1;
        sam_in    = s;
        @(negedge clk);
        sam_valid = 1'b0;
    endtask

    // Codec view: sdata and lrclk sampled at each rising bclk of one frame.
    task automatic capture(input bit wait_first, input string tag,
                           output logic [SW-1:0] left, output logic [SW-1:0] right,
                           output logic [2*SW-1:0] lr, output logic ur);
        left  = '0;
        right = '0;
        lr    = '0;
        if (wait_first) wait_fs(tag);
        ur = underrun;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 2 * SW; i++) begin
            if (i < SW) left[SW-1-i] = sdata;
            else        right[2*SW-1-i] = sdata;
            lr[2*SW-1-i] = lrclk;
            if (i < 2 * SW - 1) repeat (2 * D) @(negedge clk);
        end
    endtask

    // scoreboard: pops the expected slot pattern for the captured frame
    task automatic frame_check(input string tag, input bit wait_first, input logic exp_ur);
        logic [SW-1:0]   left;
        logic [SW-1:0]   right;
        logic [2*SW-1:0] lr;
        logic            ur;
        logic [SW-1:0]   exp;
        capture(wait_first, tag, left, right, lr, ur);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_left"},     64'(left),  64'(exp));
        check({tag, "_right"},    64'(right), 64'(exp));
        check({tag, "_lrclk"},    64'(lr),    64'(LR_PATTERN));
        check({tag, "_underrun"}, 64'(ur),    64'(exp_ur));
    endtask

    initial begin
        vec_t          vecs[8];
        int            ur_cnt, fs_cnt, sd_cnt, bh_cnt, lh_cnt, rl_cnt, rdy_hi, i;
        logic [DW-1:0] s;

        vecs[0] = '{24'hABCDEF, 32'h55E6F780};
        vecs[1] = '{24'h000001, 32'h00000080};
        vecs[2] = '{24'h800000, 32'h40000000};
        vecs[3] = '{24'h7FFFFF, 32'h3FFFFF80};
        vecs[4] = '{24'hFFFFFF, 32'h7FFFFF80};
        vecs[5] = '{24'h000000, 32'h00000000};
        vecs[6] = '{24'h555555, 32'h2AAAAA80};
        vecs[7] = '{24'h123456, 32'h091A2B00};

        rst       = 1'b0;
        sam_valid = 1'b0;
        sam_in    = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bclk, lrclk, sdata, sam_ready, frame_start, underrun}),
              64'(6'b000100));
        rst = 1'b1;

        // idle: two full frames with nothing offered
        ur_cnt = 0; fs_cnt = 0; sd_cnt = 0; bh_cnt = 0; lh_cnt = 0; rl_cnt = 0;
        repeat (2 * FRAME_CLKS) begin
            @(negedge clk);
            ur_cnt += int'(underrun);
            fs_cnt += int'(frame_start);
            sd_cnt += int'(sdata);
            bh_cnt += int'(bclk);
            lh_cnt += int'(lrclk);
            rl_cnt += int'(!sam_ready);
        end
        check("idle_underruns",    64'(ur_cnt), 64'(2));
        check("idle_frame_starts", 64'(fs_cnt), 64'(2));
        check("idle_sdata_ones",   64'(sd_cnt), 64'(0));
        check("idle_bclk_high",    64'(bh_cnt), 64'(256));
        check("idle_lrclk_high",   64'(lh_cnt), 64'(253));
        check("idle_ready_low",    64'(rl_cnt), 64'(0));

        // table: one sample per entry, delivered mid-frame, sent in the next frame
        for (int v = 0; v < 8; v++) begin
            wait_fs($sformatf("vec%0d_pre", v));
            repeat ($urandom_range(4, 100)) @(negedge clk);
            send_sample($sformatf("vec%0d", v), vecs[v].sample);
            exp_q.push_back(vecs[v].slot);
            frame_check($sformatf("vec%0d", v), 1'b1, 1'b0);
        end

        // back-pressure: 0x000001 then 0x800000 held valid
        wait_fs("bp_pre");
        repeat (5) @(negedge clk);
        sam_valid = 1'b1;
        sam_in    = 24'h000001;
        @(negedge clk);
        check("bp_first_accepted", 64'(sam_ready), 64'(0));
        sam_in = 24'h800000;
        rdy_hi = 0;
        i      = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && i < FRAME_CLKS + 16) begin
            rdy_hi += int'(sam_ready);
            @(negedge clk);
            i++;
        end
        check("bp_load_seen", 64'(frame_start), 64'(1));
        check("bp_ready_low_until_load", 64'(rdy_hi), 64'(0));
        check("bp_ready_at_load", 64'(sam_ready), 64'(1));
        exp_q.push_back(slot_of(24'h000001));
        exp_q.push_back(slot_of(24'h800000));
        frame_check("bp_first", 1'b0, 1'b0);
        frame_check("bp_second", 1'b1, 1'b0);
        sam_valid = 1'b0;

        // underrun: one sample then nothing, so the next frame repeats it
        wait_fs("ur_pre");
        repeat (10) @(negedge clk);
        send_sample("ur", 24'h7FFFFF);
        exp_q.push_back(32'h3FFFFF80);
        exp_q.push_back(32'h3FFFFF80);
        frame_check("ur_first", 1'b1, 1'b0);
        frame_check("ur_repeat", 1'b1, 1'b1);

        // one-clk reset at left-slot position 10
        wait_fs("rst_pre");
        repeat (10 * 2 * D) @(negedge clk);
        check("rst_pre_lrclk", 64'(lrclk), 64'(0));
        check("rst_pre_sdata", 64'(sdata), 64'(1));
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", 64'({bclk, lrclk, sdata, sam_ready, frame_start, underrun}),
              64'(6'b000100));
        rst = 1'b1;
        repeat (2 * D - 1) @(negedge clk);
        check("rst_no_early_edge", 64'({bclk, frame_start}), 64'(2'b10));
        @(negedge clk);
        check("rst_first_fall", 64'({bclk, lrclk, frame_start, underrun}), 64'(4'b0011));

        // accept in the same clk as an empty frame load
        repeat (FRAME_CLKS - 1) @(negedge clk);
        s         = DW'($urandom);
        sam_valid = 1'b1;
        sam_in    = s;
        @(negedge clk);
        sam_valid = 1'b0;
        check("sim_frame_start", 64'(frame_start), 64'(1));
        check("sim_underrun",    64'(underrun),    64'(1));
        check("sim_accepted",    64'(sam_ready),   64'(0));
        exp_q.push_back(32'h0);
        exp_q.push_back(slot_of(s));
        frame_check("sim_empty_frame", 1'b0, 1'b1);
        frame_check("sim_next_frame", 1'b1, 1'b0);

        // randomized traffic with one short reset, checked by the cycle model
        for (int c = 0; c < 3000; c++) begin
            sam_valid = ($urandom_range(0, 3) == 0);
            sam_in    = DW'($urandom);
            rst       = (c == 1700) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        sam_valid = 1'b0;
        rst       = 1'b1;
        repeat (20) @(negedge clk);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
